// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin two-requester arbiter that sequences whole-word reads/writes into RAM opcode commands
module ram_port_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_wr,
  input  logic [ADDR_SIZE-1:0] req0_addr,
  input  logic [ADDR_SIZE-1:0] req0_wdata,
  output logic                 rsp0_valid,
  output logic [ADDR_SIZE-1:0] rsp0_rdata,
  output logic                 rsp0_err,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_wr,
  input  logic [ADDR_SIZE-1:0] req1_addr,
  input  logic [ADDR_SIZE-1:0] req1_wdata,
  output logic                 rsp1_valid,
  output logic [ADDR_SIZE-1:0] rsp1_rdata,
  output logic                 rsp1_err,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 busy
);
  localparam int CW = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(RD_LATENCY - 1);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RCMD, RWAIT, RESP} state_t;
  state_t state;
  logic last_grant, grant, wr, sel, accept, sel_wr, done, res_err;
  logic [ADDR_SIZE-1:0] addr, wdata, sel_addr, sel_wdata, res_rdata;
  logic [CW-1:0] cnt;
  always_comb begin
    sel = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    accept = state == IDLE && (req0_valid || req1_valid);
    req0_ready = accept && !sel;
    req1_ready = accept && sel;
    busy = state != IDLE;
    sel_wr = sel ? req1_wr : req0_wr;
    sel_addr = sel ? req1_addr : req0_addr;
    sel_wdata = sel ? req1_wdata : req0_wdata;
    done = state == WDATA || (state == RWAIT && cnt == LAST);
    res_rdata = (state == RWAIT && ram_tx_valid) ? ram_dout : '0;
    res_err = state == RWAIT && !ram_tx_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      grant <= 1'b0;
      wr <= 1'b0;
      addr <= '0;
      wdata <= '0;
      cnt <= '0;
      ram_din <= '0;
      ram_rx_valid <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state <= ADDR;
          grant <= sel;
          last_grant <= sel;
          wr <= sel_wr;
          addr <= sel_addr;
          wdata <= sel_wdata;
          ram_rx_valid <= 1'b1;
          ram_din <= {sel_wr ? 2'b00 : 2'b10, sel_addr};
        end
        ADDR: begin
          state <= wr ? WDATA : RCMD;
          ram_din <= wr ? {2'b01, wdata} : {2'b11, {ADDR_SIZE{1'b0}}};
        end
        WDATA: begin
          state <= RESP;
          ram_rx_valid <= 1'b0;
          ram_din <= '0;
        end
        RCMD: begin
          state <= RWAIT;
          ram_rx_valid <= 1'b0;
          ram_din <= '0;
          cnt <= '0;
        end
        RWAIT: begin
          state <= done ? RESP : RWAIT;
          cnt <= cnt + CW'(1);
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (done && grant) begin
        rsp1_valid <= 1'b1;
        rsp1_rdata <= res_rdata;
        rsp1_err <= res_err;
      end
      if (done && !grant) begin
        rsp0_valid <= 1'b1;
        rsp0_rdata <= res_rdata;
        rsp0_err <= res_err;
      end
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: vector, corner-case and randomized checks of ram_port_arbiter against a RAM model
module tb_ram_port_arbiter;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req0_wr = 0, req1_valid = 0, req1_wr = 0;
  logic [7:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [7:0] rsp0_rdata, rsp1_rdata, ram_dout;
  logic [9:0] ram_din;
  logic ram_rx_valid, ram_tx_valid, busy;
  logic fault = 0;
  logic [7:0] mem [256];
  logic [7:0] waddr = 0, raddr = 0, dout_q = 0;
  logic txv_q = 0;
  logic [7:0] ref_mem [256];
  int n_chk = 0, n_fail = 0;
  typedef struct { int r; bit wr; logic [7:0] a, d, exp_rd; bit exp_err, flt; } vec_t;
  typedef struct { bit v; bit wr; logic [7:0] a, d; } req_t;
  vec_t tbl [9];
  req_t pend [2];
  req_t cur;
  logic [7:0] pool [4] = '{8'h3C, 8'h00, 8'hFF, 8'h80};
  logic [7:0] ca [2][2] = '{'{8'h3C, 8'h00}, '{8'hFF, 8'h80}};
  logic [7:0] cd [2][2] = '{'{8'h11, 8'h22}, '{8'h33, 8'h44}};
  always #5 clk = ~clk;
  ram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid), .busy(busy)
  );
  always @(posedge clk) begin
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: begin waddr <= ram_din[7:0]; txv_q <= 1'b0; end
        2'b01: begin mem[waddr] <= ram_din[7:0]; txv_q <= 1'b0; end
        2'b10: begin raddr <= ram_din[7:0]; txv_q <= 1'b0; end
        default: begin dout_q <= mem[raddr]; txv_q <= 1'b1; end
      endcase
    end
  end
  assign ram_dout = dout_q;
  assign ram_tx_valid = txv_q & ~fault;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input int r, input bit v, input bit wr, input logic [7:0] a, input logic [7:0] d);
    if (r == 0) begin req0_valid = v; req0_wr = wr; req0_addr = a; req0_wdata = d; end
    else begin req1_valid = v; req1_wr = wr; req1_addr = a; req1_wdata = d; end
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  task automatic txn(input vec_t v);
    @(posedge clk); #1;
    drive(v.r, 1, v.wr, v.a, v.d);
    fault = v.flt;
    @(negedge clk);
    chk("own_ready", v.r == 0 ? req0_ready : req1_ready, 1);
    chk("other_ready", v.r == 0 ? req1_ready : req0_ready, 0);
    @(posedge clk); #1;
    drive(v.r, 0, 0, 0, 0);
    @(negedge clk);
    chk("cmd1", ram_din, {v.wr ? 2'b00 : 2'b10, v.a});
    chk("cmd1_strobe", ram_rx_valid, 1);
    chk("cmd1_busy", busy, 1);
    @(negedge clk);
    chk("cmd2", ram_din, v.wr ? {2'b01, v.d} : {2'b11, 8'h00});
    chk("cmd2_strobe", ram_rx_valid, 1);
    if (!v.wr) begin
      @(negedge clk);
      chk("rwait_strobe", ram_rx_valid, 0);
      chk("rwait_no_rsp", rsp0_valid | rsp1_valid, 0);
    end
    @(negedge clk);
    chk("rsp_own", v.r == 0 ? rsp0_valid : rsp1_valid, 1);
    chk("rsp_other", v.r == 0 ? rsp1_valid : rsp0_valid, 0);
    chk("rsp_rdata", v.r == 0 ? rsp0_rdata : rsp1_rdata, v.exp_rd);
    chk("rsp_err", v.r == 0 ? rsp0_err : rsp1_err, v.exp_err);
    chk("resp_din_zero", {ram_rx_valid, ram_din}, 0);
    @(negedge clk);
    chk("rsp_one_cycle", rsp0_valid | rsp1_valid, 0);
    chk("idle_busy", busy, 0);
    fault = 0;
  endtask
  function automatic req_t mk();
    req_t q;
    q.v = 1;
    q.wr = 1'($urandom_range(1, 0));
    q.a = pool[$urandom_range(3, 0)];
    q.d = 8'($urandom);
    return q;
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end
  initial begin
    int w, g, lat, lg, c0, c1;
    int idx [2];
    tbl[0] = '{0, 1, 8'h3C, 8'hA5, 8'h00, 0, 0};
    tbl[1] = '{1, 0, 8'h3C, 8'h00, 8'hA5, 0, 0};
    tbl[2] = '{0, 1, 8'h00, 8'hFF, 8'h00, 0, 0};
    tbl[3] = '{1, 1, 8'hFF, 8'h00, 8'h00, 0, 0};
    tbl[4] = '{0, 0, 8'h00, 8'h00, 8'hFF, 0, 0};
    tbl[5] = '{1, 0, 8'hFF, 8'h00, 8'h00, 0, 0};
    tbl[6] = '{0, 1, 8'h80, 8'h5A, 8'h00, 0, 0};
    tbl[7] = '{1, 0, 8'h80, 8'h00, 8'h00, 1, 1};
    tbl[8] = '{0, 0, 8'h80, 8'h00, 8'h5A, 0, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobe", ram_rx_valid, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_rdata", {rsp0_rdata, rsp1_rdata}, 0);
    chk("rst_err", {rsp0_err, rsp1_err}, 0);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 9; i++) begin
      txn(tbl[i]);
      if (tbl[i].wr) ref_mem[tbl[i].a] = tbl[i].d;
      if (i == 2) chk("rdata_hold", rsp1_rdata, 8'hA5);
    end
    do_reset();
    idx[0] = 0; idx[1] = 0;
    drive(0, 1, 1, ca[0][0], cd[0][0]);
    drive(1, 1, 1, ca[1][0], cd[1][0]);
    for (int k = 0; k < 4; k++) begin
      w = 0;
      @(negedge clk);
      while (!(req0_ready || req1_ready) && w < 10) begin @(negedge clk); w++; end
      chk("cont_grant_wait", w < 10, 1);
      g = req1_ready ? 1 : 0;
      chk("cont_grant", g, k % 2);
      chk("cont_single_ready", req0_ready && req1_ready, 0);
      ref_mem[ca[g][idx[g]]] = cd[g][idx[g]];
      idx[g]++;
      @(posedge clk); #1;
      if (idx[g] < 2) drive(g, 1, 1, ca[g][idx[g]], cd[g][idx[g]]);
      else drive(g, 0, 0, 0, 0);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!(rsp0_valid || rsp1_valid) && lat < 8);
      chk("cont_latency", lat, 3);
      chk("cont_rsp_own", g == 0 ? rsp0_valid : rsp1_valid, 1);
      chk("cont_rsp_other", g == 0 ? rsp1_valid : rsp0_valid, 0);
    end
    lg = 1;
    pend[0].v = 0; pend[1].v = 0;
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 2; r++) if (!pend[r].v && $urandom_range(1, 0) == 1) pend[r] = mk();
      if (!pend[0].v && !pend[1].v) pend[$urandom_range(1, 0)] = mk();
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) drive(r, pend[r].v, pend[r].wr, pend[r].a, pend[r].d);
      @(negedge clk);
      w = (pend[0].v && pend[1].v) ? 1 - lg : (pend[1].v ? 1 : 0);
      chk("rnd_ready0", req0_ready, w == 0);
      chk("rnd_ready1", req1_ready, w == 1);
      lg = w;
      cur = pend[w];
      pend[w].v = 0;
      @(posedge clk); #1;
      drive(w, 0, 0, 0, 0);
      @(negedge clk);
      chk("rnd_cmd1", ram_din, {cur.wr ? 2'b00 : 2'b10, cur.a});
      chk("rnd_busy_ready", req0_ready | req1_ready, 0);
      @(negedge clk);
      chk("rnd_cmd2", ram_din, cur.wr ? {2'b01, cur.d} : {2'b11, 8'h00});
      lat = 2;
      do begin @(negedge clk); lat++; end while (!(rsp0_valid || rsp1_valid) && lat < 8);
      chk("rnd_latency", lat, cur.wr ? 3 : 4);
      chk("rnd_rsp_own", w == 0 ? rsp0_valid : rsp1_valid, 1);
      chk("rnd_rsp_other", w == 0 ? rsp1_valid : rsp0_valid, 0);
      chk("rnd_rdata", w == 0 ? rsp0_rdata : rsp1_rdata, cur.wr ? 8'h00 : ref_mem[cur.a]);
      chk("rnd_err", w == 0 ? rsp0_err : rsp1_err, 0);
      if (cur.wr) ref_mem[cur.a] = cur.d;
    end
    for (int r = 0; r < 2; r++) drive(r, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 1, 1, 8'h80, 8'h11);
    @(negedge clk);
    chk("drop_ready0", req0_ready, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 8'h80, 8'h00);
    @(negedge clk);
    chk("drop_busy_ready1", req1_ready, 0);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0);
    c0 = 0; c1 = 0;
    repeat (4) begin @(negedge clk); c0 += int'(rsp0_valid); c1 += int'(rsp1_valid); end
    chk("drop_rsp0_count", c0, 1);
    chk("drop_rsp1_count", c1, 0);
    ref_mem[8'h80] = 8'h11;
    @(posedge clk); #1;
    drive(0, 1, 0, 8'h3C, 8'h00);
    @(negedge clk);
    chk("rstmid_ready0", req0_ready, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rstmid_rcmd", ram_din, 10'h300);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rstmid_strobe", ram_rx_valid, 0);
    chk("rstmid_din", ram_din, 0);
    chk("rstmid_busy", busy, 0);
    c0 = 0;
    repeat (5) begin @(negedge clk); c0 += int'(rsp0_valid) + int'(rsp1_valid); end
    chk("rstmid_no_rsp", c0, 0);
    @(posedge clk); #1;
    drive(0, 1, 1, 8'h3C, 8'h01);
    drive(1, 1, 1, 8'hFF, 8'h02);
    @(negedge clk);
    chk("rstmid_tie_ready0", req0_ready, 1);
    chk("rstmid_tie_ready1", req1_ready, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Two-requester round-robin arbiter and command sequencer for the single-port SPI-side RAM model (10-bit command word, 2-bit opcode plus 8-bit payload).
- Converts each requester's whole-word write or read transaction into the RAM's opcode sequence:
  - write: 00 = set write address, then 01 = write data.
  - read: 10 = set read address, then 11 = read.
- For reads, captures the returned byte and hands a response back to the granted requester.
- Sits between the two requesters (SPI slave path, test/debug master) and the RAM.

Parameters:
ADDR_SIZE, 8, width of address and data fields; RAM command word is ADDR_SIZE+2 bits.
RD_LATENCY, 1, cycles from the 11 command cycle to valid ram_dout/ram_tx_valid.

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 transaction pending
req0_ready  out  1  requester 0 transaction accepted this cycle
req0_wr  in  1  1 = write, 0 = read
req0_addr  in  ADDR_SIZE  target address
req0_wdata  in  ADDR_SIZE  write data (ignored for reads)
rsp0_valid  out  1  one-cycle completion pulse for requester 0
rsp0_rdata  out  ADDR_SIZE  read data, valid with rsp0_valid on reads
rsp0_err  out  1  read completed without ram_tx_valid
req1_*/rsp1_*  same set for requester 1
ram_din  out  ADDR_SIZE+2  command word to RAM
ram_rx_valid  out  1  command strobe to RAM
ram_dout  in  ADDR_SIZE  RAM read data
ram_tx_valid  in  1  RAM read-data valid (sticky in RAM until next non-read command)
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset
  - Synchronous, active-high, highest priority.
  - Outputs on reset: state = IDLE; ram_rx_valid = 0; ram_din = 0; rsp*_valid = 0; rsp*_rdata = 0; rsp*_err = 0; busy = 0; last_grant = 1, so requester 0 wins the first tie.
  - Reset mid-transaction abandons it: no response pulse, and ram_rx_valid drops the cycle after rst is sampled.
- Request handshake
  - A requester holds valid and all fields stable until valid && ready.
  - req*_ready is combinational and asserted only in IDLE, for the granted requester only.
  - The address and data fields are latched on the accept edge.
- Arbitration (IDLE only)
  - Only one requester valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - last_grant updates on accept.
- FSM states: IDLE, ADDR, WDATA, RCMD, RWAIT, RESP.
  - IDLE -> ADDR on accept.
  - ADDR: ram_rx_valid = 1. Write: ram_din = {2'b00, addr}, next WDATA. Read: ram_din = {2'b10, addr}, next RCMD.
  - WDATA: ram_rx_valid = 1, ram_din = {2'b01, wdata}; next RESP.
  - RCMD: ram_rx_valid = 1, ram_din = {2'b11, 8'h00}; next RWAIT.
  - RWAIT: ram_rx_valid = 0; stays RD_LATENCY cycles.
    - On the last cycle, if ram_tx_valid = 1: capture ram_dout into rdata, err = 0.
    - Otherwise: rdata = 0, err = 1.
    - Next RESP.
  - RESP: rsp<g>_valid = 1 for exactly one cycle to the granted requester only; rdata/err valid for reads, rdata = 0 and err = 0 for writes; next IDLE.
- Register and output-path rules
  - ram_din and ram_rx_valid are registered, with no combinational path from req inputs.
  - ram_din = 0 whenever ram_rx_valid = 0.
  - rsp*_rdata holds its last value until the next response to that requester.
- Latency, with accept at cycle T
  - Write: RAM commands at T+1 and T+2; rsp_valid at T+3.
  - Read (RD_LATENCY = 1): commands at T+1 and T+2; capture at T+3; rsp_valid at T+4.
  - Next accept is possible at the cycle after RESP.
  - Back-to-back throughput: one write per 4 cycles, one read per 5 cycles.
- Boundaries
  - Addresses 8'h00 and 8'hFF pass unchanged; no wrap logic.
  - A requester dropping valid without ready is legal (no accept).
  - Requests arriving while busy wait; ready stays low.
  - A requester whose valid stays high while the other is served is granted in the next IDLE if the other also requests (fairness, no starvation).

Test Plan:
- Reset then single write: req0 wr, addr 8'h3C, data 8'hA5 -> ram_din 10'h03C at T+1, 10'h1A5 at T+2, rsp0_valid at T+3, rsp1_valid never asserts.
- Read-back: req1 read addr 8'h3C after the above -> ram_din 10'h23C then 10'h300, rsp1_valid at T+4 with rsp1_rdata 8'hA5, rsp1_err 0.
- Contention: both valid continuously, alternating writes -> grants alternate 0,1,0,1 starting with 0; each response goes only to its own requester.
- Boundary addresses: write 8'hFF to 8'h00 and 8'h00 to 8'hFF, then read both -> data returned uncorrupted, no opcode bits bleed into the payload.
- RAM fault: force ram_tx_valid low during RWAIT -> rsp_valid with rdata 8'h00, err 1.
- Reset mid-read: assert rst in RCMD -> ram_rx_valid 0 the next cycle, no rsp pulse, and the first post-reset tie goes to requester 0.
